// File: rtl/mac_pipe_param.sv
// mac_pipe_param: three-stage pipelined multiply-accumulate unit.
// Supports configurable operand/accumulator widths, per-beat signed or unsigned
// operation and accumulator clear, optional saturation with a sticky overflow
// flag, and valid/ready handshakes on both sides. The whole pipe freezes while
// the sink holds off a pending result.
module mac_pipe_param #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              signed_mode,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int PROD_W = 2 * DATA_W;

    if (ACC_W < PROD_W) begin : gBadWidth
        $error("mac_pipe_param: ACC_W must be at least 2*DATA_W");
    end

    localparam logic [ACC_W-1:0] SIGNED_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SIGNED_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] UNSIGNED_MAX = {ACC_W{1'b1}};

    // Stage 1: captured operands
    logic              s1Valid_q;
    logic [DATA_W-1:0] s1A_q;
    logic [DATA_W-1:0] s1B_q;
    logic              s1Signed_q;
    logic              s1Clear_q;

    // Stage 2: extended product
    logic              s2Valid_q;
    logic [ACC_W-1:0]  s2Prod_q;
    logic              s2Signed_q;
    logic              s2Clear_q;

    // Stage 3: accumulator and output state
    logic              outValid_q;
    logic [ACC_W-1:0]  acc_q;
    logic              ovf_q;

    logic              stall;
    logic              advance;
    logic              inFire;
    logic              retire;
    logic [PROD_W-1:0] aExt_d;
    logic [PROD_W-1:0] bExt_d;
    logic [PROD_W-1:0] prodFull_d;
    logic [ACC_W-1:0]  prodExt_d;
    logic [ACC_W:0]    sum_d;
    logic              ovf_d;
    logic [ACC_W-1:0]  accNext_d;

    // A result the sink has not taken freezes every stage; reset also blocks intake.
    assign stall     = outValid_q & ~out_ready;
    assign advance   = ~stall;
    assign in_ready  = ~rst & ~stall;
    assign inFire    = in_valid & in_ready;
    assign retire    = advance & s2Valid_q;
    assign out_valid = outValid_q;
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

    // Stage 1 captures a beat on input transfer; a bubble is recorded when none arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s1A_q      <= '0;
            s1B_q      <= '0;
            s1Signed_q <= 1'b0;
            s1Clear_q  <= 1'b0;
        end else if (advance) begin
            s1Valid_q <= inFire;
            if (inFire) begin
                s1A_q      <= a;
                s1B_q      <= b;
                s1Signed_q <= signed_mode;
                s1Clear_q  <= clear;
            end
        end
    end

    // Operands are widened according to the beat's mode, so one multiplier covers both modes.
    always_comb begin
        aExt_d     = {{DATA_W{s1Signed_q & s1A_q[DATA_W-1]}}, s1A_q};
        bExt_d     = {{DATA_W{s1Signed_q & s1B_q[DATA_W-1]}}, s1B_q};
        prodFull_d = aExt_d * bExt_d;
        prodExt_d  = {ACC_W{s1Signed_q & prodFull_d[PROD_W-1]}};
        prodExt_d[PROD_W-1:0] = prodFull_d;
    end

    // Stage 2 holds the accumulator-width product together with its beat controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Valid_q  <= 1'b0;
            s2Prod_q   <= '0;
            s2Signed_q <= 1'b0;
            s2Clear_q  <= 1'b0;
        end else if (advance) begin
            s2Valid_q  <= s1Valid_q;
            s2Prod_q   <= prodExt_d;
            s2Signed_q <= s1Signed_q;
            s2Clear_q  <= s1Clear_q;
        end
    end

    // Add with one spare bit, detect overflow in the beat's mode, then clamp or wrap.
    always_comb begin
        sum_d     = {1'b0, acc_q} + {1'b0, s2Prod_q};
        ovf_d     = 1'b0;
        accNext_d = sum_d[ACC_W-1:0];
        if (s2Clear_q) begin
            accNext_d = s2Prod_q;
        end else begin
            if (s2Signed_q) begin
                ovf_d = (acc_q[ACC_W-1] == s2Prod_q[ACC_W-1]) &&
                        (sum_d[ACC_W-1] != acc_q[ACC_W-1]);
            end else begin
                ovf_d = sum_d[ACC_W];
            end
            if (ovf_d && SATURATE) begin
                if (s2Signed_q) begin
                    accNext_d = s2Prod_q[ACC_W-1] ? SIGNED_MIN : SIGNED_MAX;
                end else begin
                    accNext_d = UNSIGNED_MAX;
                end
            end
        end
    end

    // Stage 3 retires a beat into the accumulator; bubbles drop out_valid and keep acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            acc_q      <= '0;
        end else if (advance) begin
            outValid_q <= s2Valid_q;
            if (s2Valid_q) begin
                acc_q <= accNext_d;
            end
        end
    end

    // Sticky overflow: setting beats win over clr_ovf and over clearing beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (retire && ovf_d) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf || (retire && s2Clear_q)) begin
            ovf_q <= 1'b0;
        end
    end

endmodule
